// File: rtl/xstop_boot_ctrl.sv
// Boot/run sequencer for the XSTop core: timed reset release, interrupt gating,
// halt/critical-error monitoring and a watchdog with bounded auto-restart.
module xstop_boot_ctrl #(
    parameter int unsigned VEC_W         = 48,
    parameter int unsigned NINTR         = 64,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned WDT_W         = 24,
    parameter logic [WDT_W-1:0] WDT_TIMEOUT = {WDT_W{1'b1}},
    parameter int unsigned MAX_RESTARTS  = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [VEC_W-1:0] rst_vec_in,
    input  logic             wdt_kick,
    input  logic             core_halt,
    input  logic             core_crit_err,
    input  logic [NINTR-1:0] ext_intrs_in,
    output logic             core_rst,
    output logic [VEC_W-1:0] core_rst_vec,
    output logic [NINTR-1:0] ext_intrs_out,
    output logic [2:0]       state,
    output logic [1:0]       fault_cause,
    output logic [7:0]       restart_cnt
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAssert  = 3'd1,
        StRelease = 3'd2,
        StRun     = 3'd3,
        StHalted  = 3'd4,
        StFault   = 3'd5
    } state_e;

    localparam int unsigned CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WDT_W-1:0] WDT_LAST    = WDT_TIMEOUT - WDT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WDT_W-1:0]   wdt_q, wdt_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [NINTR-1:0]   intrs_q, intrs_d;
    logic [1:0]         cause_q, cause_d;
    logic [7:0]         restart_q, restart_d;
    logic               core_rst_q, core_rst_d;
    logic               wdt_expire;
    logic               accept;

    // A kick in the expiry cycle suppresses the expiry.
    assign wdt_expire = (WDT_TIMEOUT != '0) && !wdt_kick && (wdt_q == WDT_LAST);

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cause_d   = cause_q;
        restart_d = restart_q;
        accept    = 1'b0;
        cnt_d     = '0;
        wdt_d     = '0;

        if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) accept = 1'b1;
                end
                StAssert: begin
                    if (cnt_q == '0) state_d = StRelease;
                end
                StRelease: begin
                    if (core_crit_err) begin
                        state_d = StFault;
                        cause_d = 2'd1;
                    end else if (cnt_q == '0) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (core_crit_err) begin
                        state_d = StFault;
                        cause_d = 2'd1;
                    end else if (wdt_expire) begin
                        if (32'(restart_q) < MAX_RESTARTS) begin
                            state_d = StAssert;
                            if (restart_q != 8'hFF) restart_d = restart_q + 8'd1;
                        end else begin
                            state_d = StFault;
                            cause_d = 2'd2;
                        end
                    end else if (core_halt) begin
                        state_d = StHalted;
                    end
                end
                StHalted: begin
                    if (core_crit_err) begin
                        state_d = StFault;
                        cause_d = 2'd1;
                    end else if (start) begin
                        accept = 1'b1;
                    end
                end
                StFault: begin
                    if (start) accept = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end

        if (accept) begin
            state_d   = StAssert;
            vec_d     = rst_vec_in;
            cause_d   = 2'd0;
            restart_d = 8'd0;
        end

        // Phase counters reload on every entry, including watchdog restarts.
        if (state_d == StAssert && state_q != StAssert) begin
            cnt_d = RST_LOAD;
        end else if (state_d == StRelease && state_q != StRelease) begin
            cnt_d = SETTLE_LOAD;
        end else if (state_d == state_q && (state_q == StAssert || state_q == StRelease)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (state_d == StRun && state_q == StRun && !wdt_kick) begin
            wdt_d = wdt_q + WDT_W'(1);
        end

        intrs_d    = (state_q == StRun) ? ext_intrs_in : '0;
        core_rst_d = !(state_d == StRelease || state_d == StRun || state_d == StHalted);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            wdt_q      <= '0;
            vec_q      <= '0;
            intrs_q    <= '0;
            cause_q    <= 2'd0;
            restart_q  <= 8'd0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wdt_q      <= wdt_d;
            vec_q      <= vec_d;
            intrs_q    <= intrs_d;
            cause_q    <= cause_d;
            restart_q  <= restart_d;
            core_rst_q <= core_rst_d;
        end
    end

    assign core_rst      = core_rst_q;
    assign core_rst_vec  = vec_q;
    assign ext_intrs_out = intrs_q;
    assign state         = state_q;
    assign fault_cause   = cause_q;
    assign restart_cnt   = restart_q;

endmodule

// File: tb/tb_xstop_boot_ctrl.sv
// Self-checking bench for xstop_boot_ctrl with a 100-cycle watchdog.
module tb_xstop_boot_ctrl;

    localparam int unsigned VEC_W = 48;
    localparam int unsigned NINTR = 64;
    localparam logic [2:0] S_IDLE = 3'd0, S_ASSERT = 3'd1, S_RELEASE = 3'd2;
    localparam logic [2:0] S_RUN = 3'd3, S_HALTED = 3'd4, S_FAULT = 3'd5;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start, stop, wdt_kick, core_halt, core_crit_err;
    logic [VEC_W-1:0] rst_vec_in;
    logic [NINTR-1:0] ext_intrs_in;
    logic             core_rst;
    logic [VEC_W-1:0] core_rst_vec;
    logic [NINTR-1:0] ext_intrs_out;
    logic [2:0]       state;
    logic [1:0]       fault_cause;
    logic [7:0]       restart_cnt;

    int total = 0;
    int bad   = 0;
    logic [NINTR-1:0] sb[$];

    xstop_boot_ctrl #(
        .WDT_TIMEOUT (24'd100)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .stop          (stop),
        .rst_vec_in    (rst_vec_in),
        .wdt_kick      (wdt_kick),
        .core_halt     (core_halt),
        .core_crit_err (core_crit_err),
        .ext_intrs_in  (ext_intrs_in),
        .core_rst      (core_rst),
        .core_rst_vec  (core_rst_vec),
        .ext_intrs_out (ext_intrs_out),
        .state         (state),
        .fault_cause   (fault_cause),
        .restart_cnt   (restart_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (state !== s) begin
            bad++;
            $display("FAIL %s: state=%0d required=%0d after %0d cycles", tag, state, s, n);
        end
    endtask

    task automatic do_start(input logic [VEC_W-1:0] vec);
        rst_vec_in = vec;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        rst_vec_in = {16'hDEAD, $urandom()};
        total++;
        if (state !== S_ASSERT || core_rst_vec !== vec || restart_cnt !== 8'd0
            || fault_cause !== 2'd0) begin
            bad++;
            $display("FAIL start_accept: state=%0d vec=%h rc=%0d fc=%0d required 1/%h/0/0",
                     state, core_rst_vec, restart_cnt, fault_cause, vec);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; stop = 1'b0; wdt_kick = 1'b0; core_halt = 1'b0;
        core_crit_err = 1'b0; rst_vec_in = '0; ext_intrs_in = 64'hF;
        repeat (3) tick();
        total++;
        if (state !== S_IDLE || core_rst !== 1'b1 || core_rst_vec !== '0 || ext_intrs_out !== '0
            || fault_cause !== 2'd0 || restart_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_values: st=%0d rst=%b vec=%h int=%h fc=%0d rc=%0d",
                     state, core_rst, core_rst_vec, ext_intrs_out, fault_cause, restart_cnt);
        end
        rstn = 1'b1;
        repeat (2) tick();
        total++;
        if (state !== S_IDLE || core_rst !== 1'b1) begin
            bad++;
            $display("FAIL idle_hold: state=%0d core_rst=%b required 0/1", state, core_rst);
        end
    endtask

    // Full 16-cycle assert, 8-cycle settle, then interrupts open one cycle into RUN.
    task automatic test_boot(input logic [VEC_W-1:0] vec);
        ext_intrs_in = 64'hF;
        do_start(vec);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (state !== S_ASSERT || core_rst !== 1'b1 || ext_intrs_out !== '0) begin
                bad++;
                $display("FAIL boot_assert[%0d]: st=%0d rst=%b int=%h required 1/1/0",
                         i, state, core_rst, ext_intrs_out);
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (state !== S_RELEASE || core_rst !== 1'b0 || ext_intrs_out !== '0) begin
                bad++;
                $display("FAIL boot_release[%0d]: st=%0d rst=%b int=%h required 2/0/0",
                         i, state, core_rst, ext_intrs_out);
            end
            tick();
        end
        total++;
        if (state !== S_RUN || core_rst !== 1'b0 || ext_intrs_out !== '0 || core_rst_vec !== vec)
        begin
            bad++;
            $display("FAIL boot_run_entry: st=%0d rst=%b int=%h vec=%h required 3/0/0/%h",
                     state, core_rst, ext_intrs_out, core_rst_vec, vec);
        end
        tick();
        total++;
        if (ext_intrs_out !== 64'hF) begin
            bad++;
            $display("FAIL boot_intr_open: ext_intrs_out=%h required %h", ext_intrs_out, 64'hF);
        end
    endtask

    task automatic test_intr_scoreboard();
        logic [NINTR-1:0] v, exp;
        wdt_kick = 1'b1;
        for (int i = 0; i < 24; i++) begin
            v = {$urandom(), $urandom()};
            ext_intrs_in = v;
            sb.push_back(v);
            tick();
            exp = sb.pop_front();
            total++;
            if (ext_intrs_out !== exp || state !== S_RUN) begin
                bad++;
                $display("FAIL intr_pass[%0d]: out=%h st=%0d required %h/3",
                         i, ext_intrs_out, state, exp);
            end
        end
    endtask

    task automatic test_halt_gating();
        ext_intrs_in = 64'hF;
        tick();
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        total++;
        if (state !== S_HALTED || core_rst !== 1'b0 || ext_intrs_out !== 64'hF) begin
            bad++;
            $display("FAIL halt_enter: st=%0d rst=%b int=%h required 4/0/f",
                     state, core_rst, ext_intrs_out);
        end
        tick();
        total++;
        if (state !== S_HALTED || ext_intrs_out !== '0) begin
            bad++;
            $display("FAIL halt_gate: st=%0d int=%h required 4/0", state, ext_intrs_out);
        end
    endtask

    task automatic test_kick();
        int not_run = 0;
        wdt_kick = 1'b0;
        test_boot(48'h1000_0000);
        for (int i = 0; i < 300; i++) begin
            wdt_kick = ((i % 50) == 49);
            tick();
            if (state !== S_RUN) not_run++;
        end
        wdt_kick = 1'b0;
        total++;
        if (not_run !== 0 || restart_cnt !== 8'd0) begin
            bad++;
            $display("FAIL wdt_kicked: cycles_out_of_run=%0d rc=%0d required 0/0",
                     not_run, restart_cnt);
        end
    endtask

    // One expiry bumps restart_cnt; a halt then reboot with a new vector clears it.
    task automatic test_restart_then_reboot();
        wdt_kick = 1'b0;
        wait_state(S_ASSERT, 200, "wdt_first_expiry");
        total++;
        if (restart_cnt !== 8'd1 || core_rst_vec !== 48'h1000_0000) begin
            bad++;
            $display("FAIL wdt_restart1: rc=%0d vec=%h required 1/10000000",
                     restart_cnt, core_rst_vec);
        end
        wait_state(S_RUN, 40, "rerun_after_restart");
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        total++;
        if (state !== S_HALTED || core_rst !== 1'b0) begin
            bad++;
            $display("FAIL halt_in_run: st=%0d rst=%b required 4/0", state, core_rst);
        end
        do_start(48'h2000_4000);
    endtask

    task automatic test_watchdog();
        int n;
        wdt_kick = 1'b0;
        wait_state(S_RUN, 40, "wdt_boot");
        for (int r = 1; r <= 4; r++) begin
            n = 0;
            while (state === S_RUN && n < 200) begin
                tick();
                n++;
            end
            total++;
            if (r < 4) begin
                if (n !== 100 || state !== S_ASSERT || restart_cnt !== 8'(r) || core_rst !== 1'b1)
                begin
                    bad++;
                    $display("FAIL wdt_restart[%0d]: run_cycles=%0d st=%0d rc=%0d required 100/1/%0d",
                             r, n, state, restart_cnt, r);
                end
                wait_state(S_RUN, 40, "wdt_rerun");
            end else begin
                if (n !== 100 || state !== S_FAULT || fault_cause !== 2'd2
                    || restart_cnt !== 8'd3 || core_rst !== 1'b1) begin
                    bad++;
                    $display("FAIL wdt_fault: run_cycles=%0d st=%0d fc=%0d rc=%0d required 100/5/2/3",
                             n, state, fault_cause, restart_cnt);
                end
            end
        end
    endtask

    task automatic test_priority();
        do_start(48'h3000_0000);
        wait_state(S_RUN, 40, "prio_boot");
        repeat (99) tick();
        core_crit_err = 1'b1;
        tick();
        core_crit_err = 1'b0;
        total++;
        if (state !== S_FAULT || fault_cause !== 2'd1 || restart_cnt !== 8'd0) begin
            bad++;
            $display("FAIL crit_over_wdt: st=%0d fc=%0d rc=%0d required 5/1/0",
                     state, fault_cause, restart_cnt);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++;
        if (state !== S_IDLE || fault_cause !== 2'd1 || core_rst !== 1'b1) begin
            bad++;
            $display("FAIL stop_from_fault: st=%0d fc=%0d rst=%b required 0/1/1",
                     state, fault_cause, core_rst);
        end
    endtask

    task automatic test_stop_start_halted();
        test_boot(48'h4000_0000);
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        stop       = 1'b1;
        start      = 1'b1;
        rst_vec_in = 48'h5555_0000;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        total++;
        if (state !== S_IDLE || core_rst !== 1'b1 || core_rst_vec !== 48'h4000_0000) begin
            bad++;
            $display("FAIL stop_beats_start: st=%0d rst=%b vec=%h required 0/1/40000000",
                     state, core_rst, core_rst_vec);
        end
    endtask

    task automatic test_async_reset();
        do_start(48'h6000_0000);
        wait_state(S_RELEASE, 40, "async_to_release");
        repeat (3) tick();
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if (state !== S_IDLE || core_rst !== 1'b1 || core_rst_vec !== '0 || ext_intrs_out !== '0
            || fault_cause !== 2'd0 || restart_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: st=%0d rst=%b vec=%h int=%h fc=%0d rc=%0d",
                     state, core_rst, core_rst_vec, ext_intrs_out, fault_cause, restart_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        test_boot(48'h1000_0000);
    endtask

    initial begin
        test_reset();
        test_boot(48'h1000_0000);
        test_intr_scoreboard();
        test_halt_gating();
        test_kick();
        test_restart_then_reboot();
        test_watchdog();
        test_priority();
        test_stop_start_halted();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
